// File: rtl/h264_mem_arbiter.sv
// ----------------------------------------------------------------------------
// h264_mem_arbiter
//
// Shares one external single-port memory between the fetch unit (single-word
// reads) and the bitstream packer (word writes). Each transaction is sequenced
// by a small FSM; simultaneous requests are resolved round-robin. Only one
// memory transaction is ever outstanding.
//
// Build option:
//   H264_ARB_WBUF_EN  defined   -> WBUF_DEPTH-entry posted-write FIFO in front
//                                  of the arbiter. The packer sees ready while
//                                  space exists; a full FIFO forces write
//                                  priority.
//                     undefined -> packer is stalled until its own write is
//                                  acked by memory (pk_wready_o = ack).
//
// Ports:
//   clk, rst                      clock, asynchronous active-low reset
//   fetch_req_i/addr_i            read request, held until fetch_gnt_o
//   fetch_gnt_o                   pulse when memory accepts the read
//   fetch_rvalid_o/rdata_o        registered read-data return (1-cycle pulse)
//   pk_wreq_i/waddr_i/wdata_i     write request, held until accepted
//   pk_wready_o                   write accepted when pk_wreq_i & pk_wready_o
//   mem_req_o/we_o/addr_o/wdata_o registered memory request, held until ack
//   mem_ack_i                     memory accepts the current request
//   mem_rvalid_i/rdata_i          memory read-data return
//   busy_o                        FSM not idle, or write FIFO non-empty
// ----------------------------------------------------------------------------
module h264_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] fetch_addr_i,
    output logic              fetch_gnt_o,
    output logic              fetch_rvalid_o,
    output logic [DATA_W-1:0] fetch_rdata_o,
    input  logic              pk_wreq_i,
    input  logic [ADDR_W-1:0] pk_waddr_i,
    input  logic [DATA_W-1:0] pk_wdata_i,
    output logic              pk_wready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic              mem_rvalid_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              busy_o
);

    if (WBUF_DEPTH < 2 || (WBUF_DEPTH & (WBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("h264_mem_arbiter: WBUF_DEPTH must be a power of 2 and >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_RET,
        S_WR_ISSUE
    } state_t;

    state_t            r_state;
    logic              r_last_gnt_wr;   // 1: last grant went to the write side
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_fetch_rdata;
    logic              r_fetch_rvalid;

    // Write source seen by the arbiter (FIFO head or the packer directly)
    logic              w_wsrc_valid;
    logic [ADDR_W-1:0] w_wsrc_addr;
    logic [DATA_W-1:0] w_wsrc_data;
    logic              w_wbuf_full;
    logic              w_wbuf_busy;
    logic              w_wr_ack;
    logic              w_rd_win;
    logic              w_wr_win;

    assign w_wr_ack = (r_state == S_WR_ISSUE) & mem_ack_i;

`ifdef H264_ARB_WBUF_EN
    localparam int PTR_W = $clog2(WBUF_DEPTH);

    logic [ADDR_W-1:0] r_wbuf_addr [WBUF_DEPTH];
    logic [DATA_W-1:0] r_wbuf_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_push;
    logic              w_pop;

    // Depth is a power of two, so the count MSB alone marks "full"
    assign w_wbuf_full  = r_count[PTR_W];
    assign pk_wready_o  = ~w_wbuf_full;
    assign w_push       = pk_wreq_i & ~w_wbuf_full;
    assign w_pop        = w_wr_ack;
    assign w_wsrc_valid = (r_count != '0);
    assign w_wsrc_addr  = r_wbuf_addr[r_rd_ptr];
    assign w_wsrc_data  = r_wbuf_data[r_rd_ptr];
    assign w_wbuf_busy  = w_wsrc_valid;

    // Storage needs no reset: entries are only read when counted valid
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_wbuf_addr[r_wr_ptr] <= pk_waddr_i;
            r_wbuf_data[r_wr_ptr] <= pk_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
`else
    assign w_wbuf_full  = 1'b0;
    assign w_wbuf_busy  = 1'b0;
    assign w_wsrc_valid = pk_wreq_i;
    assign w_wsrc_addr  = pk_waddr_i;
    assign w_wsrc_data  = pk_wdata_i;
    // The packer's own transfer completes in the memory ack cycle
    assign pk_wready_o  = w_wr_ack;
`endif

    // Round-robin: on contention the side not granted last wins, except that
    // a full write FIFO always takes the port.
    assign w_rd_win = fetch_req_i &
                      (~w_wsrc_valid | (~w_wbuf_full & r_last_gnt_wr));
    assign w_wr_win = w_wsrc_valid & ~w_rd_win;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_last_gnt_wr  <= 1'b1;
            r_mem_req      <= 1'b0;
            r_mem_we       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_fetch_rdata  <= '0;
            r_fetch_rvalid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_win) begin
                        r_mem_addr    <= fetch_addr_i;
                        r_mem_we      <= 1'b0;
                        r_mem_req     <= 1'b1;
                        r_last_gnt_wr <= 1'b0;
                        r_state       <= S_RD_ISSUE;
                    end else if (w_wr_win) begin
                        r_mem_addr    <= w_wsrc_addr;
                        r_mem_wdata   <= w_wsrc_data;
                        r_mem_we      <= 1'b1;
                        r_mem_req     <= 1'b1;
                        r_last_gnt_wr <= 1'b1;
                        r_state       <= S_WR_ISSUE;
                    end
                end
                S_RD_ISSUE: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_state   <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (mem_rvalid_i) begin
                        r_fetch_rdata  <= mem_rdata_i;
                        r_fetch_rvalid <= 1'b1;
                        r_state        <= S_RD_RET;
                    end
                end
                S_RD_RET: begin
                    r_fetch_rvalid <= 1'b0;
                    r_state        <= S_IDLE;
                end
                S_WR_ISSUE: begin
                    if (mem_ack_i) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fetch_gnt_o    = (r_state == S_RD_ISSUE) & mem_ack_i;
    assign fetch_rvalid_o = r_fetch_rvalid;
    assign fetch_rdata_o  = r_fetch_rdata;
    assign mem_req_o      = r_mem_req;
    assign mem_we_o       = r_mem_we;
    assign mem_addr_o     = r_mem_addr;
    assign mem_wdata_o    = r_mem_wdata;
    assign busy_o         = (r_state != S_IDLE) | w_wbuf_busy;

endmodule

// File: tb/tb_h264_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_h264_mem_arbiter
//
// Directed, table-driven bench for h264_mem_arbiter. Each table row holds the
// inputs for one clock cycle and the outputs expected in that cycle; rows are
// driven just after the rising edge and compared on the falling edge. A few
// hand-written sequences cover asynchronous reset and the posted-write FIFO.
// ----------------------------------------------------------------------------
module tb_h264_mem_arbiter;

    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int WBUF_DEPTH = 4;
`ifdef H264_ARB_WBUF_EN
    localparam logic BUF = 1'b1;
`else
    localparam logic BUF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              fetch_req_i = 1'b0;
    logic [ADDR_W-1:0] fetch_addr_i = '0;
    logic              fetch_gnt_o;
    logic              fetch_rvalid_o;
    logic [DATA_W-1:0] fetch_rdata_o;
    logic              pk_wreq_i = 1'b0;
    logic [ADDR_W-1:0] pk_waddr_i = '0;
    logic [DATA_W-1:0] pk_wdata_i = '0;
    logic              pk_wready_o;
    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_ack_i = 1'b0;
    logic              mem_rvalid_i = 1'b0;
    logic [DATA_W-1:0] mem_rdata_i = '0;
    logic              busy_o;

    always #5 clk = ~clk;

    h264_mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .WBUF_DEPTH(WBUF_DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_req_i   (fetch_req_i),
        .fetch_addr_i  (fetch_addr_i),
        .fetch_gnt_o   (fetch_gnt_o),
        .fetch_rvalid_o(fetch_rvalid_o),
        .fetch_rdata_o (fetch_rdata_o),
        .pk_wreq_i     (pk_wreq_i),
        .pk_waddr_i    (pk_waddr_i),
        .pk_wdata_i    (pk_wdata_i),
        .pk_wready_o   (pk_wready_o),
        .mem_req_o     (mem_req_o),
        .mem_we_o      (mem_we_o),
        .mem_addr_o    (mem_addr_o),
        .mem_wdata_o   (mem_wdata_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .busy_o        (busy_o)
    );

    typedef struct {
        string       tag;
        logic        rst_n;
        logic        fr;
        logic [31:0] fa;
        logic        pw;
        logic [31:0] wa;
        logic [31:0] wd;
        logic        ack;
        logic        rv;
        logic [31:0] rd;
        logic        e_req;
        logic        e_we;
        logic [31:0] e_addr;
        logic [31:0] e_wd;
        logic        e_gnt;
        logic        e_rv;
        logic [31:0] e_rd;
        logic        e_wrdy;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(
        input string tag, input logic rn,
        input logic fr, input logic [31:0] fa,
        input logic pw, input logic [31:0] wa, input logic [31:0] wd,
        input logic ack, input logic rv, input logic [31:0] rd,
        input logic ereq, input logic ewe, input logic [31:0] eaddr, input logic [31:0] ewd,
        input logic egnt, input logic erv, input logic [31:0] erd,
        input logic ewrdy, input logic ebusy);
        vec_t v;
        v.tag = tag; v.rst_n = rn; v.fr = fr; v.fa = fa; v.pw = pw; v.wa = wa; v.wd = wd;
        v.ack = ack; v.rv = rv; v.rd = rd; v.e_req = ereq; v.e_we = ewe; v.e_addr = eaddr;
        v.e_wd = ewd; v.e_gnt = egnt; v.e_rv = erv; v.e_rd = erd; v.e_wrdy = ewrdy; v.e_busy = ebusy;
        vecs.push_back(v);
    endfunction

    // One reset cycle: every output at its reset value
    function automatic void add_rst(input string tag);
        add(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, BUF, 0);
    endfunction

    task automatic drive_idle();
        fetch_req_i = 0; fetch_addr_i = '0; pk_wreq_i = 0; pk_waddr_i = '0; pk_wdata_i = '0;
        mem_ack_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 0;
        drive_idle();
        @(posedge clk); #1;
        rst = 1;
    endtask

    initial begin
        logic w;
        w = BUF;

        // Single read: addr 0x100, ack on first request cycle, rvalid 3 cycles later
        add_rst("A_rst");
        add("A0", 1, 1, 'h100, 0, 0, 0, 0, 0, 0,           0, 0, 0, 0,         0, 0, 0,            w, 0);
        add("A1", 1, 1, 'h100, 0, 0, 0, 1, 0, 0,           1, 0, 'h100, 0,     1, 0, 0,            w, 1);
        add("A2", 1, 0, 0,     0, 0, 0, 0, 0, 0,           0, 0, 'h100, 0,     0, 0, 0,            w, 1);
        add("A3", 1, 0, 0,     0, 0, 0, 0, 0, 0,           0, 0, 'h100, 0,     0, 0, 0,            w, 1);
        add("A4", 1, 0, 0,     0, 0, 0, 0, 1, 'hDEADBEEF,  0, 0, 'h100, 0,     0, 0, 0,            w, 1);
        add("A5", 1, 0, 0,     0, 0, 0, 0, 0, 0,           0, 0, 'h100, 0,     0, 1, 'hDEADBEEF,   w, 1);
        add("A6", 1, 0, 0,     0, 0, 0, 0, 0, 0,           0, 0, 'h100, 0,     0, 0, 'hDEADBEEF,   w, 0);
        // Stray rvalid while idle must be ignored
        add("A7", 1, 0, 0,     0, 0, 0, 0, 1, 'h0BAD0BAD,  0, 0, 'h100, 0,     0, 0, 'hDEADBEEF,   w, 0);
        add("A8", 1, 0, 0,     0, 0, 0, 0, 0, 0,           0, 0, 'h100, 0,     0, 0, 'hDEADBEEF,   w, 0);
`ifndef H264_ARB_WBUF_EN
        // Contention from reset: R, W, R, W with immediate ack and rvalid +1
        add_rst("B_rst");
        add("B0",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 0, 0,          0, 0, 0, 0,          0, 0, 0,           0, 0);
        add("B1",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 0, 0,          1, 0, 'h400, 0,      1, 0, 0,           0, 1);
        add("B2",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 1, 'h5555AAAA, 0, 0, 'h400, 0,      0, 0, 0,           0, 1);
        add("B3",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 0, 0,          0, 0, 'h400, 0,      0, 1, 'h5555AAAA,  0, 1);
        add("B4",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 0, 0,          0, 0, 'h400, 0,      0, 0, 'h5555AAAA,  0, 0);
        add("B5",  1, 1, 'h400, 1, 'h800, 'hA1, 1, 0, 0,          1, 1, 'h800, 'hA1,   0, 0, 'h5555AAAA,  1, 1);
        add("B6",  1, 1, 'h400, 1, 'h800, 'hA2, 1, 0, 0,          0, 0, 'h800, 'hA1,   0, 0, 'h5555AAAA,  0, 0);
        add("B7",  1, 1, 'h400, 1, 'h800, 'hA2, 1, 0, 0,          1, 0, 'h400, 'hA1,   1, 0, 'h5555AAAA,  0, 1);
        add("B8",  1, 1, 'h400, 1, 'h800, 'hA2, 1, 1, 'h12345678, 0, 0, 'h400, 'hA1,   0, 0, 'h5555AAAA,  0, 1);
        add("B9",  1, 1, 'h400, 1, 'h800, 'hA2, 1, 0, 0,          0, 0, 'h400, 'hA1,   0, 1, 'h12345678,  0, 1);
        add("B10", 1, 1, 'h400, 1, 'h800, 'hA2, 1, 0, 0,          0, 0, 'h400, 'hA1,   0, 0, 'h12345678,  0, 0);
        add("B11", 1, 1, 'h400, 1, 'h800, 'hA2, 1, 0, 0,          1, 1, 'h800, 'hA2,   0, 0, 'h12345678,  1, 1);
        // Slow ack: request/address/data stable for 5 un-acked cycles, one transfer
        add_rst("C_rst");
        add("C0", 1, 0, 0, 1, 'h2000, 'hCAFEF00D, 0, 0, 0,  0, 0, 0, 0,                 0, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++)
            add($sformatf("C%0d", i), 1, 0, 0, 1, 'h2000, 'hCAFEF00D, 0, 0, 0,
                1, 1, 'h2000, 'hCAFEF00D, 0, 0, 0, 0, 1);
        add("C6", 1, 0, 0, 1, 'h2000, 'hCAFEF00D, 1, 0, 0,  1, 1, 'h2000, 'hCAFEF00D,  0, 0, 0, 1, 1);
        add("C7", 1, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 'h2000, 'hCAFEF00D,  0, 0, 0, 0, 0);
        add("C8", 1, 0, 0, 0, 0, 0, 0, 0, 0,                0, 0, 'h2000, 'hCAFEF00D,  0, 0, 0, 0, 0);
`endif

        drive_idle();
        for (int k = 0; k < vecs.size(); k++) begin
            @(posedge clk); #1;
            rst          = vecs[k].rst_n;
            fetch_req_i  = vecs[k].fr;
            fetch_addr_i = vecs[k].fa;
            pk_wreq_i    = vecs[k].pw;
            pk_waddr_i   = vecs[k].wa;
            pk_wdata_i   = vecs[k].wd;
            mem_ack_i    = vecs[k].ack;
            mem_rvalid_i = vecs[k].rv;
            mem_rdata_i  = vecs[k].rd;
            @(negedge clk);
            chk({vecs[k].tag, ".req"},    mem_req_o,      vecs[k].e_req);
            chk({vecs[k].tag, ".we"},     mem_we_o,       vecs[k].e_we);
            chk({vecs[k].tag, ".addr"},   mem_addr_o,     vecs[k].e_addr);
            chk({vecs[k].tag, ".wdata"},  mem_wdata_o,    vecs[k].e_wd);
            chk({vecs[k].tag, ".gnt"},    fetch_gnt_o,    vecs[k].e_gnt);
            chk({vecs[k].tag, ".rvalid"}, fetch_rvalid_o, vecs[k].e_rv);
            chk({vecs[k].tag, ".rdata"},  fetch_rdata_o,  vecs[k].e_rd);
            chk({vecs[k].tag, ".wready"}, pk_wready_o,    vecs[k].e_wrdy);
            chk({vecs[k].tag, ".busy"},   busy_o,         vecs[k].e_busy);
        end

        // Asynchronous reset during RD_WAIT, then a late rvalid
        do_reset();
        fetch_req_i = 1; fetch_addr_i = 32'h700;
        @(posedge clk); #1;
        mem_ack_i = 1;
        @(posedge clk); #1;
        fetch_req_i = 0; mem_ack_i = 0;
        @(negedge clk);
        chk("ar.busy_before", busy_o, 1'b1);
        #1 rst = 0;
        #1;
        chk("ar.busy",   busy_o,         1'b0);
        chk("ar.req",    mem_req_o,      1'b0);
        chk("ar.addr",   mem_addr_o,     32'h0);
        chk("ar.gnt",    fetch_gnt_o,    1'b0);
        chk("ar.rvalid", fetch_rvalid_o, 1'b0);
        chk("ar.wready", pk_wready_o,    BUF);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        mem_rvalid_i = 1; mem_rdata_i = 32'h77777777;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ar.late_rvalid%0d", i), fetch_rvalid_o, 1'b0);
            chk($sformatf("ar.late_busy%0d", i),   busy_o,         1'b0);
            chk($sformatf("ar.late_rdata%0d", i),  fetch_rdata_o,  32'h0);
            @(posedge clk); #1;
            mem_rvalid_i = 0;
        end

`ifdef H264_ARB_WBUF_EN
        begin
            logic [31:0] wdat [5];
            logic [31:0] wlog_d [5];
            logic [31:0] wlog_a [5];
            int          nw;
            int          nr;
            int          nw_at_gnt;
            logic        pw_pend;
            logic        fr_pend;
            logic        rv_next;
            wdat[0] = 32'hD0D0D0D0; wdat[1] = 32'hD1D1D1D1; wdat[2] = 32'hD2D2D2D2;
            wdat[3] = 32'hD3D3D3D3; wdat[4] = 32'hD4D4D4D4;

            // Five back-to-back writes, memory never acks: four fit, fifth refused
            do_reset();
            for (int i = 0; i < 5; i++) begin
                if (i > 0) begin @(posedge clk); #1; end
                pk_wreq_i = 1; pk_waddr_i = 32'h3000 + 32'(4 * i); pk_wdata_i = wdat[i];
                mem_ack_i = 0; fetch_req_i = (i == 4); fetch_addr_i = 32'h500;
                @(negedge clk);
                chk($sformatf("buf.wready%0d", i), pk_wready_o, (i < 4));
                if (i >= 2) begin
                    chk($sformatf("buf.req%0d", i),   mem_req_o,   1'b1);
                    chk($sformatf("buf.addr%0d", i),  mem_addr_o,  32'h3000);
                    chk($sformatf("buf.wdata%0d", i), mem_wdata_o, wdat[0]);
                end
            end

            // Acks resume: drain writes in order, read interleaves round-robin
            nw = 0; nr = 0; nw_at_gnt = -1; pw_pend = 1; fr_pend = 1; rv_next = 0;
            for (int cyc = 0; cyc < 60 && !(nw == 5 && nr == 1); cyc++) begin
                @(posedge clk); #1;
                mem_ack_i    = 1;
                pk_wreq_i    = pw_pend;
                fetch_req_i  = fr_pend;
                mem_rvalid_i = rv_next;
                mem_rdata_i  = rv_next ? 32'h600DCAFE : 32'h0;
                rv_next      = 0;
                @(negedge clk);
                if (pk_wreq_i && pk_wready_o) pw_pend = 0;
                if (fetch_gnt_o) begin
                    fr_pend = 0; rv_next = 1; nw_at_gnt = nw;
                    chk("buf.rd_addr", mem_addr_o, 32'h500);
                end
                if (mem_req_o && mem_ack_i && mem_we_o && nw < 5) begin
                    wlog_a[nw] = mem_addr_o; wlog_d[nw] = mem_wdata_o; nw++;
                end
                if (fetch_rvalid_o) begin
                    chk("buf.rdata", fetch_rdata_o, 32'h600DCAFE);
                    nr++;
                end
            end
            chk("buf.nwrites", nw, 5);
            chk("buf.nreads", nr, 1);
            chk("buf.rd_after_first_wr", nw_at_gnt, 1);
            for (int i = 0; i < nw; i++) begin
                chk($sformatf("buf.order_addr%0d", i), wlog_a[i], 32'h3000 + 32'(4 * i));
                chk($sformatf("buf.order_data%0d", i), wlog_d[i], wdat[i]);
            end
            @(posedge clk); #1;
            drive_idle();
            @(negedge clk);
            chk("buf.busy_end", busy_o, 1'b0);
            chk("buf.wready_end", pk_wready_o, 1'b1);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
